// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: ext_op codes and
// the skid-buffer state encoding.
package imm_ext_pkg;

  localparam logic [2:0] EXT_SM   = 3'd0;
  localparam logic [2:0] EXT_LG   = 3'd1;
  localparam logic [2:0] EXT_DIS  = 3'd2;
  localparam logic [2:0] EXT_UP   = 3'd3;
  localparam logic [2:0] EXT_ZERO = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate extractor/extender. Selects the field named by
// ext_op and widens it to N bits; reserved ops fall back to the small field
// and raise bad_op.
module imm_ext_comb #(
  parameter int N     = 16,
  parameter int SM_W  = 5,
  parameter int LG_W  = 8,
  parameter int DIS_W = 11
) (
  input  logic [N-1:0] inst,
  input  logic         ext_sign,
  input  logic [2:0]   ext_op,
  output logic [N-1:0] imm,
  output logic         bad_op
);
  import imm_ext_pkg::*;

  // Every field must leave room for at least one extension bit.
  if (SM_W >= N || LG_W >= N || DIS_W >= N || SM_W < 1 || LG_W < 1 || DIS_W < 1) begin : g_width_chk
    $error("imm_ext_comb: field widths must be in 1..N-1");
  end

  logic [N-1:0] sm_imm;
  logic [N-1:0] lg_imm;
  logic [N-1:0] dis_imm;
  logic [N-1:0] up_imm;
  logic         unused_inst;

  assign sm_imm  = {{(N-SM_W){ext_sign & inst[SM_W-1]}}, inst[SM_W-1:0]};
  assign lg_imm  = {{(N-LG_W){ext_sign & inst[LG_W-1]}}, inst[LG_W-1:0]};
  assign dis_imm = {{(N-DIS_W){ext_sign & inst[DIS_W-1]}}, inst[DIS_W-1:0]};
  assign up_imm  = {inst[LG_W-1:0], {(N-LG_W){1'b0}}};
  // Upper instruction bits are not part of any field.
  assign unused_inst = ^inst;

  // Pick the extended field for the requested op.
  always_comb begin
    imm    = sm_imm;
    bad_op = 1'b0;
    case (ext_op)
      EXT_SM:   imm = sm_imm;
      EXT_LG:   imm = lg_imm;
      EXT_DIS:  imm = dis_imm;
      EXT_UP:   imm = up_imm;
      EXT_ZERO: imm = '0;
      default: begin
        imm    = sm_imm;
        bad_op = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage between decode and execute.
// Valid/ready handshake with a 2-entry skid buffer (main + skid) and
// synchronous flush. Define IMM_EXT_PERF_EN to add the stall_cnt and
// bad_op_cnt saturating performance counters.
module imm_ext_stage #(
  parameter int N     = 16,
  parameter int SM_W  = 5,
  parameter int LG_W  = 8,
  parameter int DIS_W = 11,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     inst,
  input  logic             ext_sign,
  input  logic [2:0]       ext_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     ext_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             bad_op
`ifdef IMM_EXT_PERF_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      bad_op_cnt
`endif
);
  import imm_ext_pkg::*;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [N-1:0]     main_imm_q, main_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             main_bad_q, main_bad_d;
  logic [N-1:0]     skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_bad_q, skid_bad_d;
  logic [N-1:0]     new_imm;
  logic             new_bad;
  logic             accept;

  imm_ext_comb #(.N(N), .SM_W(SM_W), .LG_W(LG_W), .DIS_W(DIS_W)) u_comb (
    .inst     (inst),
    .ext_sign (ext_sign),
    .ext_op   (ext_op),
    .imm      (new_imm),
    .bad_op   (new_bad)
  );

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign ext_imm   = main_imm_q;
  assign out_tag   = main_tag_q;
  assign bad_op    = main_bad_q;

  // Next-state and buffer steering; flush overrides any accept this cycle.
  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_tag_d = main_tag_q;
    main_bad_d = main_bad_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_bad_d = skid_bad_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d    = ST_ONE;
            main_imm_d = new_imm;
            main_tag_d = in_tag;
            main_bad_d = new_bad;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            main_imm_d = new_imm;
            main_tag_d = in_tag;
            main_bad_d = new_bad;
          end else if (accept) begin
            state_d    = ST_TWO;
            skid_imm_d = new_imm;
            skid_tag_d = in_tag;
            skid_bad_d = new_bad;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            state_d    = ST_ONE;
            main_imm_d = skid_imm_q;
            main_tag_d = skid_tag_q;
            main_bad_d = skid_bad_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // Control state; in_ready stays low through the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Output-facing main entry; cleared on reset so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_bad_q <= 1'b0;
    end else begin
      main_imm_q <= main_imm_d;
      main_tag_q <= main_tag_d;
      main_bad_q <= main_bad_d;
    end
  end

  // Skid entry is only read when state is TWO, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_imm_q <= skid_imm_d;
    skid_tag_q <= skid_tag_d;
    skid_bad_q <= skid_bad_d;
  end

`ifdef IMM_EXT_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  // Saturating counters; a flushed input is not an accept.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (accept && !flush && new_bad && bad_cnt_q != 16'hFFFF)
      bad_cnt_d = bad_cnt_q + 16'd1;
  end

  // Counters clear on reset only.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      bad_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bad_op_cnt = bad_cnt_q;
`endif

endmodule

// File: tb/tb_imm_ext_stage.sv
// Testbench for imm_ext_stage: directed scenarios plus randomized traffic
// against a queue-based reference model. Exercises IMM_EXT_PERF_EN counters
// when that macro is defined.
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        ext_sign = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] inst = 16'h0;
  logic [2:0]  ext_op = 3'd0;
  logic [3:0]  in_tag = 4'h0;
  logic        in_ready;
  logic        out_valid;
  logic        bad_op;
  logic [15:0] ext_imm;
  logic [3:0]  out_tag;
`ifdef IMM_EXT_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] bad_op_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_ext_stage #(.N(16), .SM_W(5), .LG_W(8), .DIS_W(11), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .ext_sign  (ext_sign),
    .ext_op    (ext_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ext_imm   (ext_imm),
    .out_tag   (out_tag),
    .bad_op    (bad_op)
`ifdef IMM_EXT_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bad_op_cnt(bad_op_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] imm;
    logic [3:0]  tag;
    logic        bad;
  } ent_t;

  ent_t exp_q[$];
  bit   m_rdy = 1'b0;
  int   m_stall = 0;
  int   m_bad = 0;

  function automatic logic [15:0] ref_field(input int w, input logic [15:0] v, input logic s);
    int unsigned f;
    f = int'(v) % (1 << w);
    if (s && f >= (1 << (w - 1))) f = f + 65536 - (1 << w);
    return f[15:0];
  endfunction

  function automatic ent_t ref_ent(input logic [15:0] v, input logic s, input logic [2:0] op,
                                   input logic [3:0] t);
    ent_t e;
    int unsigned u;
    e.tag = t;
    e.bad = 1'b0;
    case (op)
      3'd0: e.imm = ref_field(5, v, s);
      3'd1: e.imm = ref_field(8, v, s);
      3'd2: e.imm = ref_field(11, v, s);
      3'd3: begin
        u = (int'(v) % 256) * 256;
        e.imm = u[15:0];
      end
      3'd4: e.imm = 16'h0000;
      default: begin
        e.imm = ref_field(5, v, s);
        e.bad = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Advance the model with the currently driven inputs, then one clock.
  task automatic tick();
    bit acc;
    acc = in_valid && m_rdy;
    if (rst) begin
      exp_q.delete();
      m_rdy = 1'b0;
      m_stall = 0;
      m_bad = 0;
    end else begin
      if (exp_q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
      if (flush) begin
        exp_q.delete();
        m_rdy = 1'b1;
      end else begin
        if (acc && ext_op >= 3'd5 && m_bad < 65535) m_bad++;
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ref_ent(inst, ext_sign, ext_op, in_tag));
        m_rdy = (exp_q.size() < 2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tables ----------------
  logic [2:0]  t_op   [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd4, 3'd1};
  logic        t_sign [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] t_inst [8] = '{16'h0013, 16'h0013, 16'h0080, 16'h0400,
                              16'h12AB, 16'h001F, 16'hFFFF, 16'h0080};
  logic [15:0] t_exp  [8] = '{16'hFFF3, 16'h0013, 16'hFF80, 16'hFC00,
                              16'hAB00, 16'hFFFF, 16'h0000, 16'h0080};
  logic        t_bad  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (ext_imm !== 16'h0) begin errors++; $display("FAIL reset_ext_imm: got %h expected 0000", ext_imm); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    checks++; if (bad_op !== 1'b0) begin errors++; $display("FAIL reset_bad_op: got %b expected 0", bad_op); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_extension();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      ext_op   = t_op[i];
      ext_sign = t_sign[i];
      inst     = t_inst[i];
      in_tag   = 4'(i + 3);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ext_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (ext_imm !== t_exp[i]) begin errors++; $display("FAIL ext_imm[%0d]: got %h expected %h", i, ext_imm, t_exp[i]); end
      checks++; if (out_tag !== 4'(i + 3)) begin errors++; $display("FAIL ext_tag[%0d]: got %h expected %h", i, out_tag, 4'(i + 3)); end
      checks++; if (bad_op !== t_bad[i]) begin errors++; $display("FAIL ext_bad[%0d]: got %b expected %b", i, bad_op, t_bad[i]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] got[$];
    out_ready = 1'b0; in_valid = 1'b1; ext_op = 3'd0; ext_sign = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      in_tag = 4'(t);
      inst   = 16'(t);
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    checks++; if (out_tag !== 4'd1) begin errors++; $display("FAIL bp_hold_tag: got %h expected 1", out_tag); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) got.push_back(out_tag);
      if (in_valid && m_rdy) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++; if (got[k] !== 4'(k + 1)) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", k, got[k], 4'(k + 1)); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; ext_op = 3'd1; ext_sign = 1'b1; inst = 16'h00F0;
    in_tag = 4'd6; tick();
    in_tag = 4'd7; tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_in_ready: got %b expected 0", in_ready); end
    in_tag = 4'd5; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got valid tag %h expected none", c, out_tag); end
      tick();
    end
  endtask

  task automatic test_reserved_and_reset();
    out_ready = 1'b0; in_valid = 1'b1; ext_op = 3'd6; ext_sign = 1'b1; inst = 16'h001F;
    in_tag = 4'd9; tick();
    in_tag = 4'd10; tick();
    in_valid = 1'b0;
    checks++; if (ext_imm !== 16'hFFFF) begin errors++; $display("FAIL rsv_imm: got %h expected FFFF", ext_imm); end
    checks++; if (bad_op !== 1'b1) begin errors++; $display("FAIL rsv_bad: got %b expected 1", bad_op); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rsv_two_in_ready: got %b expected 0", in_ready); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++; if (ext_imm !== 16'h0) begin errors++; $display("FAIL midrst_imm: got %h expected 0000", ext_imm); end
    checks++; if (bad_op !== 1'b0) begin errors++; $display("FAIL midrst_bad: got %b expected 0", bad_op); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_release_valid: got %b expected 0", out_valid); end
  endtask

`ifdef IMM_EXT_PERF_EN
  task automatic test_perf();
    out_ready = 1'b0; in_valid = 1'b1; ext_sign = 1'b0; inst = 16'h0003;
    ext_op = 3'd6; in_tag = 4'd1; tick();
    ext_op = 3'd5; in_tag = 4'd2; tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL perf_stall: got %0d expected 4", stall_cnt); end
    checks++; if (bad_op_cnt !== 16'd2) begin errors++; $display("FAIL perf_bad: got %0d expected 2", bad_op_cnt); end
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL perf_flush_stall: got %0d expected 4", stall_cnt); end
    checks++; if (bad_op_cnt !== 16'd2) begin errors++; $display("FAIL perf_flush_bad: got %0d expected 2", bad_op_cnt); end
    rst = 1'b1;
    tick();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL perf_rst_stall: got %0d expected 0", stall_cnt); end
    checks++; if (bad_op_cnt !== 16'd0) begin errors++; $display("FAIL perf_rst_bad: got %0d expected 0", bad_op_cnt); end
    rst = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (out_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, out_valid, exp_q.size() > 0);
      end
      checks++;
      if (in_ready !== m_rdy) begin
        errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", c, in_ready, m_rdy);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (ext_imm !== exp_q[0].imm || out_tag !== exp_q[0].tag || bad_op !== exp_q[0].bad) begin
          errors++;
          $display("FAIL rnd_data[%0d]: got imm %h tag %h bad %b expected imm %h tag %h bad %b",
                   c, ext_imm, out_tag, bad_op, exp_q[0].imm, exp_q[0].tag, exp_q[0].bad);
        end
      end
`ifdef IMM_EXT_PERF_EN
      checks++;
      if (stall_cnt !== 16'(m_stall) || bad_op_cnt !== 16'(m_bad)) begin
        errors++;
        $display("FAIL rnd_perf[%0d]: got stall %0d bad %0d expected stall %0d bad %0d",
                 c, stall_cnt, bad_op_cnt, m_stall, m_bad);
      end
`endif
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      flush     = ($urandom_range(0, 99) < 3);
      inst      = 16'($urandom);
      ext_op    = 3'($urandom_range(0, 7));
      ext_sign  = 1'($urandom_range(0, 1));
      in_tag    = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_extension();
    test_backpressure();
    test_flush();
    test_reserved_and_reset();
`ifdef IMM_EXT_PERF_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
- Registered, parametrised successor to the decode-stage immediate extender; sits between decode and execute.
- Extracts and sign/zero-extends the immediate field of an instruction word and adds a shifted-upper mode.
- Carries a sideband tag alongside the immediate.
- Decouples decode from execute with a valid/ready handshake, a 2-entry skid buffer, and synchronous flush.

Parameters:
- N, 16, datapath/instruction width.
- SM_W, 5, small immediate field width, bits [SM_W-1:0].
- LG_W, 8, large immediate field width, bits [LG_W-1:0].
- DIS_W, 11, displacement field width, bits [DIS_W-1:0].
- TAG_W, 4, sideband tag width (pipeline ID/PC tag).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; registered.
- inst  in  N  instruction word.
- ext_sign  in  1  1 = sign-extend, 0 = zero-extend.
- ext_op  in  3  0 small, 1 large, 2 displacement, 3 upper, 4 zero; 5-7 reserved.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  registered immediate valid.
- out_ready  in  1  downstream accepts.
- ext_imm  out  N  extended immediate.
- out_tag  out  TAG_W  tag aligned with ext_imm.
- bad_op  out  1  entry used a reserved ext_op (5-7).

Behaviour:
- Extension is combinational on input and registered at accept. Latency is 1 cycle from accept (in_valid && in_ready) to out_valid.
- op 0: field inst[SM_W-1:0], extended to N by ext_sign using bit SM_W-1.
- op 1: same as op 0 using LG_W.
- op 2: same as op 0 using DIS_W.
- op 3 (upper): {inst[LG_W-1:0], (N-LG_W) zeros}; ext_sign ignored.
- op 4: all zeros.
- op 5-7: treated as op 0 with bad_op=1 stored for that entry.
- Field widths must be < N; elaboration error otherwise.
- States: EMPTY (no entries), ONE (main valid), TWO (main + skid valid).
- EMPTY: accept -> ONE.
- ONE:
  - accept && out_ready -> ONE, main replaced.
  - accept && !out_ready -> TWO, new entry into skid.
  - !accept && out_ready -> EMPTY.
- TWO:
  - out_ready -> ONE, skid moves to main.
  - in_ready is low in TWO, so no accept is possible.
- in_ready = registered (next_state != TWO).
- out_valid = state != EMPTY.
- ext_imm, out_tag and bad_op hold stable while out_valid && !out_ready.
- Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- flush: next state EMPTY and in_ready=1 next cycle. Any input presented in the flush cycle is dropped even if in_valid && in_ready. out_ready in that cycle is ignored for bookkeeping; the current out entry still counts as consumed by downstream if handshaken.
- rst (also mid-operation): state EMPTY; out_valid=0, ext_imm=0, out_tag=0, bad_op=0.
- in_ready is 0 during the reset cycle and 1 the cycle after rst deasserts.
- rst has priority over flush, and flush over accept.
- Data registers update only on accept or skid->main move; no X propagation from idle inputs.

Optional Feature:
- Macro: IMM_EXT_PERF_EN.
- With it: adds outputs stall_cnt (16b) and bad_op_cnt (16b).
  - stall_cnt increments each cycle out_valid && !out_ready.
  - bad_op_cnt increments on each accept with ext_op >= 5.
  - Both saturate at 16'hFFFF.
  - Both clear on rst only; flush does not clear them.
- Without it: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/include imm_ext_pkg holds:
  - ext_op localparams EXT_SM=3'd0, EXT_LG=3'd1, EXT_DIS=3'd2, EXT_UP=3'd3, EXT_ZERO=3'd4.
  - State encodings ST_EMPTY, ST_ONE, ST_TWO.
- One natural sub-module: imm_ext_comb, purely combinational (inst, ext_sign, ext_op) -> (imm, bad_op), parametrised by N/SM_W/LG_W/DIS_W.
- The top holds the skid buffer, FSM and optional counters.

Test Plan:
- Extension: op=0, sign=1, inst=16'h0013, tag=3 -> next cycle ext_imm=16'hFFF3, out_tag=3, out_valid=1. Same with sign=0 -> 16'h0013.
- Ops 1-3: op=1, sign=1, inst=16'h0080 -> 16'hFF80. op=2, sign=1, inst=16'h0400 -> 16'hFC00. op=3, inst=16'h12AB -> 16'hAB00.
- Backpressure: out_ready=0, stream tags 1,2,3 with in_valid=1 -> tag 1 held at output, tag 2 in skid, in_ready=0, tag 3 held upstream. Raise out_ready -> outputs 1,2,3 in order, none lost.
- Flush: TWO state plus in_valid with tag 5 and flush=1 -> next cycle out_valid=0, in_ready=1; tag 5 never appears.
- Reserved op and reset: op=6, inst=16'h001F, sign=1 -> ext_imm=16'hFFFF, bad_op=1. rst mid-stream in TWO -> next cycle out_valid=0, ext_imm=0, in_ready=0; in_ready=1 the cycle after.
- IMM_EXT_PERF_EN: 4 cycles out_valid && !out_ready plus 2 reserved-op accepts -> stall_cnt=4, bad_op_cnt=2. After flush both are unchanged; after rst both are 0.
